rv32_alu_add_sub_mc: RTL and testbench
======================================

RV32_ALU_ADD_SUB_MC -- requirements
Module: rv32_alu_add_sub_mc

Interface
REQ-001 Parameter XLEN, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per cycle; XLEN % CHUNK != 0 SHALL be an elaboration error; NCHUNK = XLEN/CHUNK.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operation request.
REQ-006 in_ready  out  1  block can accept a request.
REQ-007 alu_opsel  in  4  operation select.
REQ-008 opA, opB  in  XLEN  operands.
REQ-009 out_valid  out  1  result available.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 result  out  XLEN  sum/difference.
REQ-012 flag_z, flag_c, flag_v  out  1 each  zero, carry-out, signed overflow (present only per REQ-030).

Function
REQ-013 Opsel decode: 0, 7, 15 = ADD (opA+opB); 1, 8 = SUB (opA-opB, computed as opA + ~opB + 1); all other codes = INVALID.
REQ-014 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept on in_valid && in_ready: latch opA, opB (inverted for SUB), carry register = 1 for SUB else 0, chunk counter = 0; go BUSY for ADD/SUB, go DONE directly for INVALID.
REQ-017 BUSY: each cycle add slice [k*CHUNK +: CHUNK] of both latched operands plus carry register, write sum slice into result, update carry register, increment k, LSB slice first.
REQ-018 After slice NCHUNK-1 is written, go DONE; out_valid SHALL assert exactly NCHUNK cycles after the accepting edge (4 for defaults); INVALID: 1 cycle, result = 0.
REQ-019 DONE: result and flags held stable while out_ready = 0; on out_valid && out_ready go IDLE; no new request accepted in that same cycle.
REQ-020 Inputs other than out_ready and rst_n SHALL be ignored outside IDLE.
REQ-021 flag_z = (result == 0); flag_c = final carry-out (SUB: 1 = no borrow); flag_v = signed overflow of XLEN-bit two's-complement operation; all flags 0 for INVALID.
REQ-022 Arithmetic modulo 2^XLEN; no saturation.
REQ-023 result and flags SHALL not be guaranteed valid outside DONE; they SHALL change only in BUSY or on accept.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, in_ready = 1 once rst_n is high, out_valid = 0, result = 0, all flags = 0, counter and carry = 0.
REQ-025 Reset during BUSY or DONE SHALL discard the operation with no output handshake.
REQ-026 Reset deassertion SHALL be used synchronously to clk internally for state leaving reset.

Configuration
REQ-027 Macro RV32_ALU_ADD_SUB_FLAGS_EN controls flag generation.
REQ-028 Defined: flag_z, flag_c, flag_v ports and logic present as per REQ-021.
REQ-029 Not defined: flag ports absent; carry register still used internally; result and timing identical.
REQ-030 Flag ports SHALL exist if and only if RV32_ALU_ADD_SUB_FLAGS_EN is defined.

Verification
REQ-031 ADD opsel=0, opA=0x00000005, opB=0x00000003, out_ready=1 -> out_valid 4 cycles after accept, result=0x00000008, z=0 c=0 v=0.
REQ-032 SUB opsel=8, opA=0x00000003, opB=0x00000005 -> result=0xFFFFFFFE, c=0, v=0, z=0.
REQ-033 ADD opsel=15, 0x7FFFFFFF+0x00000001 -> result=0x80000000, v=1, c=0; ADD 0xFFFFFFFF+0x00000001 -> result=0x00000000, z=1, c=1, v=0.
REQ-034 out_ready held 0 for 5 cycles in DONE -> result/flags stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
REQ-035 opsel=3 -> out_valid 1 cycle after accept, result=0, all flags 0.
REQ-036 rst_n pulsed low in second BUSY cycle -> out_valid never asserts, outputs 0, next request completes normally.

Source files
------------

// File: rtl/rv32_alu_add_sub_mc.sv
// ---------------------------------------------------------------------------
// rv32_alu_add_sub_mc
//
// Multi-cycle ADD/SUB unit. It adds CHUNK bits per clock, least significant
// slice first, and carries between slices in a single carry register. Each
// request moves through IDLE -> BUSY -> DONE. A DONE result waits for
// out_ready before the unit returns to IDLE.
//
// Parameters:
//   XLEN   operand/result width (default 32)
//   CHUNK  bits processed per BUSY cycle (default 8); XLEN must be a multiple
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request strobe, taken when in_ready is high
//   in_ready   high only in IDLE
//   alu_opsel  0/7/15 = ADD, 1/8 = SUB, anything else = INVALID
//   opA, opB   operands
//   out_valid  high only in DONE
//   out_ready  consumer accepts the result
//   result     sum or difference (0 for INVALID)
//   flag_z/c/v zero, carry-out (SUB: 1 = no borrow), signed overflow
//
// Configuration macro:
//   RV32_ALU_ADD_SUB_FLAGS_EN  when defined, adds the flag ports and the
//                              logic that drives them. Result and timing do
//                              not change.
// ---------------------------------------------------------------------------
module rv32_alu_add_sub_mc #(
   parameter int XLEN  = 32,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_opsel,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
`ifdef RV32_ALU_ADD_SUB_FLAGS_EN
   ,
   output logic            flag_z,
   output logic            flag_c,
   output logic            flag_v
`endif
);

   localparam int NCHUNK = XLEN / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int IW     = (XLEN > 1) ? $clog2(XLEN) : 1;

   generate
      if (XLEN % CHUNK != 0) begin : g_badChunk
         $error("rv32_alu_add_sub_mc: XLEN must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic              r_carry;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_result;

   logic              w_isAdd;
   logic              w_isSub;
   logic              w_accept;
   logic              w_lastChunk;
   logic [IW-1:0]     w_base;
   logic [CHUNK:0]    w_sum;
   logic [XLEN-1:0]   w_resNext;

   // Opsel decode. Several codes alias the same operation. Any code that
   // is not listed is INVALID.
   always_comb begin
      w_isAdd = 1'b0;
      w_isSub = 1'b0;
      case (alu_opsel)
         4'd0, 4'd7, 4'd15: w_isAdd = 1'b1;
         4'd1, 4'd8:        w_isSub = 1'b1;
         default:           ;
      endcase
   end

   assign w_accept    = in_valid && (r_state == IDLE);
   assign w_lastChunk = (r_cnt == CW'(NCHUNK - 1));

   // State register. Reset drops straight into IDLE. Leaving IDLE only
   // happens on a clock edge, so reset release is seen synchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and handshake outputs. INVALID requests skip BUSY. The
   // handshake cycle in DONE cannot also accept a request, because
   // in_ready is only high in IDLE.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next = (w_isAdd || w_isSub) ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (w_lastChunk) begin
               w_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // One slice adder. r_cnt selects the slice. The new slice is merged into
   // the running result so the zero flag can look at the full final word.
   always_comb begin
      w_base    = IW'(r_cnt * CHUNK);
      w_sum     = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
                + {{CHUNK{1'b0}}, r_carry};
      w_resNext = r_result;
      w_resNext[w_base +: CHUNK] = w_sum[CHUNK-1:0];
   end

   // Operand latch and slice-serial datapath. SUB stores ~opB with a carry-in
   // of 1, so BUSY always performs an addition. The result clears on every
   // accept, so INVALID leaves it at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_a      <= opA;
         r_b      <= w_isSub ? ~opB : opB;
         r_carry  <= w_isSub;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (r_state == BUSY) begin
         r_result <= w_resNext;
         r_carry  <= w_sum[CHUNK];
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   assign result = r_result;

`ifdef RV32_ALU_ADD_SUB_FLAGS_EN
   logic r_z;
   logic r_c;
   logic r_v;

   // Flags are captured on the last slice. Overflow uses the sign bits of
   // the effective addends (B already inverted for SUB) and of the result.
   // An accept clears the flags, so INVALID reports all flags as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z <= 1'b0;
         r_c <= 1'b0;
         r_v <= 1'b0;
      end else if (w_accept) begin
         r_z <= 1'b0;
         r_c <= 1'b0;
         r_v <= 1'b0;
      end else if ((r_state == BUSY) && w_lastChunk) begin
         r_z <= (w_resNext == '0);
         r_c <= w_sum[CHUNK];
         r_v <= (r_a[XLEN-1] ^ w_sum[CHUNK-1]) & (r_b[XLEN-1] ^ w_sum[CHUNK-1]);
      end
   end

   assign flag_z = r_z;
   assign flag_c = r_c;
   assign flag_v = r_v;
`endif

endmodule

// File: tb/tb_rv32_alu_add_sub_mc.sv
// ---------------------------------------------------------------------------
// tb_rv32_alu_add_sub_mc
//
// Self-checking bench for rv32_alu_add_sub_mc. Expected results come from an
// integer-arithmetic model of the ADD/SUB rules. Flag checks are compiled
// only when RV32_ALU_ADD_SUB_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_rv32_alu_add_sub_mc;

   localparam int XLEN   = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = XLEN / CHUNK;
   localparam int LIMIT  = 20;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_opsel;
   logic [XLEN-1:0] opA;
   logic [XLEN-1:0] opB;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
`ifdef RV32_ALU_ADD_SUB_FLAGS_EN
   logic            flag_z;
   logic            flag_c;
   logic            flag_v;
`endif

   int checks = 0;
   int errors = 0;

   rv32_alu_add_sub_mc #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_opsel (alu_opsel),
      .opA       (opA),
      .opB       (opB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
`ifdef RV32_ALU_ADD_SUB_FLAGS_EN
      ,
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
`endif
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model. Results come from 64-bit integer arithmetic. Carry is
   // the unsigned overflow for ADD and "a >= b" for SUB. Overflow means the
   // exact signed result does not fit in XLEN bits. It also returns the
   // expected number of edges from the accepting edge to out_valid. INVALID
   // finishes on the accepting edge, so out_valid is already high in the
   // cycle that follows.
   function automatic void refModel(input logic [3:0] sel, input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b, output logic [XLEN-1:0] res,
                                    output logic z, output logic c, output logic v,
                                    output int lat);
      longint ua, ub, sa, sb, ur, sr;
      longint smax, smin, umax;
      smax = (longint'(1) <<< (XLEN - 1)) - 1;
      smin = -smax - 1;
      umax = (longint'(1) <<< XLEN) - 1;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0; z = 1'b0; c = 1'b0; v = 1'b0; lat = 0;
      if (sel == 0 || sel == 7 || sel == 15) begin
         ur  = ua + ub;
         sr  = sa + sb;
         res = ur[XLEN-1:0];
         c   = (ur > umax);
         v   = (sr > smax) || (sr < smin);
         z   = (res == 0);
         lat = NCHUNK;
      end else if (sel == 1 || sel == 8) begin
         ur  = ua - ub;
         sr  = sa - sb;
         res = ur[XLEN-1:0];
         c   = (ua >= ub);
         v   = (sr > smax) || (sr < smin);
         z   = (res == 0);
         lat = NCHUNK;
      end
   endfunction

   // Drives random values on all request inputs. The DUT must ignore them
   // outside IDLE.
   task automatic scramble();
      in_valid  = 1'($urandom_range(0, 1));
      alu_opsel = 4'($urandom);
      opA       = $urandom;
      opB       = $urandom;
   endtask

   // Runs one full transaction and checks accept, latency, result, flags,
   // back-pressure for holdCycles and the return to IDLE.
   task automatic runOp(input string name, input logic [3:0] sel,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int holdCycles);
      logic [XLEN-1:0] eRes;
      logic eZ, eC, eV;
      int eLat, lat;
      refModel(sel, a, b, eRes, eZ, eC, eV, eLat);
      in_valid  = 1'b1;
      alu_opsel = sel;
      opA       = a;
      opB       = b;
      out_ready = (holdCycles == 0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s in_ready_before: got %b expected 1", name, in_ready);
      end
      @(posedge clk); #1;
      scramble();
      lat = 0;
      while (out_valid !== 1'b1 && lat < LIMIT) begin
         @(posedge clk); #1;
         lat++;
         scramble();
      end
      checks++;
      if (lat != eLat) begin
         errors++;
         $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, eLat);
      end
      checks++;
      if (result !== eRes || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s result: got %h in_ready %b expected %h in_ready 0",
                  name, result, in_ready, eRes);
      end
`ifdef RV32_ALU_ADD_SUB_FLAGS_EN
      checks++;
      if ({flag_z, flag_c, flag_v} !== {eZ, eC, eV}) begin
         errors++;
         $display("[TB] FAIL %s flags zcv: got %b%b%b expected %b%b%b",
                  name, flag_z, flag_c, flag_v, eZ, eC, eV);
      end
`endif
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk); #1;
         scramble();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== eRes) begin
            errors++;
            $display("[TB] FAIL %s hold%0d: got valid %b ready %b result %h expected 1 0 %h",
                     name, i, out_valid, in_ready, result, eRes);
         end
`ifdef RV32_ALU_ADD_SUB_FLAGS_EN
         checks++;
         if ({flag_z, flag_c, flag_v} !== {eZ, eC, eV}) begin
            errors++;
            $display("[TB] FAIL %s hold_flags%0d: got %b%b%b expected %b%b%b",
                     name, i, flag_z, flag_c, flag_v, eZ, eC, eV);
         end
`endif
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s release: got valid %b ready %b expected 0 1",
                  name, out_valid, in_ready);
      end
   endtask

   // Checks the outputs while reset is held and after it is released.
   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_opsel = '0;
      opA       = '0;
      opB       = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid %b result %h expected 0 0", out_valid, result);
      end
`ifdef RV32_ALU_ADD_SUB_FLAGS_EN
      checks++;
      if ({flag_z, flag_c, flag_v} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b%b%b expected 000", flag_z, flag_c, flag_v);
      end
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release: got ready %b valid %b expected 1 0", in_ready, out_valid);
      end
   endtask

   // Fixed ADD/SUB vectors, including overflow and wrap-around cases.
   task automatic test_directed();
      runOp("add_5_3",      4'd0,  32'h0000_0005, 32'h0000_0003, 0);
      runOp("sub_3_5",      4'd8,  32'h0000_0003, 32'h0000_0005, 0);
      runOp("add_ovf",      4'd15, 32'h7FFF_FFFF, 32'h0000_0001, 0);
      runOp("add_wrap",     4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 0);
      runOp("sub_equal",    4'd1,  32'h1234_5678, 32'h1234_5678, 0);
      runOp("sub_ovf",      4'd1,  32'h8000_0000, 32'h0000_0001, 0);
      runOp("add_alias7",   4'd7,  32'h00FF_00FF, 32'h0001_0001, 0);
   endtask

   // INVALID codes complete at once and return zero.
   task automatic test_invalid();
      runOp("invalid_3",  4'd3,  32'hDEAD_BEEF, 32'h1234_5678, 0);
      runOp("invalid_14", 4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
   endtask

   // Holds out_ready low for five DONE cycles. runOp also drives random
   // requests during the hold.
   task automatic test_backpressure();
      runOp("bp_add", 4'd0, 32'h8000_0000, 32'h8000_0000, 5);
      runOp("bp_sub", 4'd8, 32'h0000_0000, 32'h0000_0001, 5);
   endtask

   // Reset in the second BUSY cycle. The operation must be dropped without
   // ever raising out_valid, and the next request must complete normally.
   task automatic test_reset_mid();
      logic seenValid;
      in_valid  = 1'b1;
      alu_opsel = 4'd0;
      opA       = 32'h0102_0304;
      opB       = 32'h1111_1111;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== '0) begin
         errors++;
         $display("[TB] FAIL reset_mid_outputs: got valid %b result %h expected 0 0", out_valid, result);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seenValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seenValid = 1'b1;
      end
      checks++;
      if (seenValid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_mid_discard: got seen_valid %b ready %b expected 0 1",
                  seenValid, in_ready);
      end
      runOp("after_reset", 4'd1, 32'h0000_0010, 32'h0000_0004, 0);
   endtask

   // Random opsel codes, operands and back-pressure lengths.
   task automatic test_random();
      logic [XLEN-1:0] a, b;
      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         b = $urandom;
         if (n % 8 == 0) b = ~a + 32'd1;
         if (n % 8 == 1) a = 32'h8000_0000;
         runOp($sformatf("rand%0d", n), 4'($urandom_range(0, 15)), a, b, $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_invalid();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
